// File: rtl/tdc_readout_pkg.sv
// Shared constants and FSM state type for the TDC readout block.
// Default widths track the TDC core result word and the sequence tag.
package tdc_readout_pkg;

    localparam int unsigned TDC_DATA_W = 24;
    localparam int unsigned TDC_SEQ_W  = 8;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_ARM  = 3'd1,
        ST_WAIT = 3'd2,
        ST_CAPT = 3'd3,
        ST_HOLD = 3'd4
    } state_t;

endpackage

// File: rtl/tdc_fifo_fwft.sv
// First-word-fall-through FIFO with distributed storage and wrap-bit pointers.
// Only the pointers are reset; storage contents are don't-care after reset.
module tdc_fifo_fwft #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic [WIDTH-1:0]           din,
    output logic                       full,
    input  logic                       pop,
    output logic [WIDTH-1:0]           dout,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     level
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic             w_pop_ok;
    logic             w_push_ok;

    assign empty = (r_wr_ptr == r_rd_ptr);
    assign full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                   (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign level = r_wr_ptr - r_rd_ptr;
    assign dout  = r_mem[r_rd_ptr[AW-1:0]];

    // A pop frees the slot this cycle, so a push into a full FIFO still lands.
    assign w_pop_ok  = pop && !empty;
    assign w_push_ok = push && (!full || w_pop_ok);

    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr[AW-1:0]] <= din;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
            end
            if (w_pop_ok) begin
                r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
            end
        end
    end

endmodule

// File: rtl/tdc_readout.sv
// Arms the TDC, captures each result on its done pulse, tags it with a
// sequence number and queues it in an FWFT FIFO; counts dropped results.
module tdc_readout
    import tdc_readout_pkg::*;
#(
    parameter int unsigned DATA_W  = TDC_DATA_W,
    parameter int unsigned SEQ_W   = TDC_SEQ_W,
    parameter int unsigned DEPTH   = 16,
    parameter int unsigned HOLDOFF = 4,
    parameter int unsigned OVF_W   = 16
) (
    input  logic                       iClk,
    input  logic                       iRst_n,
    input  logic                       iRun,
    output logic                       oEnable,
    input  logic                       iDone,
    input  logic [DATA_W-1:0]          iTDC,
    output logic [SEQ_W+DATA_W-1:0]    oData,
    output logic                       oValid,
    input  logic                       iReady,
    output logic [$clog2(DEPTH):0]     oLevel,
    output logic [OVF_W-1:0]           oOverflow,
    output logic                       oBusy
);

    localparam int unsigned HD_W = $clog2(HOLDOFF + 1);

    state_t              r_state;
    logic                r_enable;
    logic                r_busy;
    logic [DATA_W-1:0]   r_tdc;
    logic [SEQ_W-1:0]    r_seq;
    logic [OVF_W-1:0]    r_ovf;
    logic [HD_W-1:0]     r_hold;

    logic                w_push;
    logic                w_full;
    logic                w_empty;
    logic                w_drop;

    assign w_push = (r_state == ST_CAPT);
    // Dropped only when full and the consumer is not freeing a slot this cycle.
    assign w_drop = w_push && w_full && !iReady;

    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            r_state  <= ST_IDLE;
            r_enable <= 1'b0;
            r_busy   <= 1'b0;
            r_tdc    <= '0;
            r_seq    <= '0;
            r_ovf    <= '0;
            r_hold   <= '0;
        end else begin
            r_enable <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (iRun) begin
                        r_state  <= ST_ARM;
                        r_enable <= 1'b1;
                        r_busy   <= 1'b1;
                    end
                end
                ST_ARM: begin
                    r_state <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (iDone) begin
                        r_state <= ST_CAPT;
                        r_tdc   <= iTDC;
                    end
                end
                ST_CAPT: begin
                    r_seq   <= r_seq + SEQ_W'(1);
                    r_hold  <= HD_W'(HOLDOFF - 1);
                    r_state <= ST_HOLD;
                    if (w_drop && (r_ovf != '1)) begin
                        r_ovf <= r_ovf + OVF_W'(1);
                    end
                end
                ST_HOLD: begin
                    if (r_hold == '0) begin
                        if (iRun) begin
                            r_state  <= ST_ARM;
                            r_enable <= 1'b1;
                        end else begin
                            r_state <= ST_IDLE;
                            r_busy  <= 1'b0;
                        end
                    end else begin
                        r_hold <= r_hold - HD_W'(1);
                    end
                end
                default: begin
                    r_state  <= ST_IDLE;
                    r_busy   <= 1'b0;
                end
            endcase
        end
    end

    tdc_fifo_fwft #(
        .WIDTH (SEQ_W + DATA_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (iClk),
        .rst_n (iRst_n),
        .push  (w_push),
        .din   ({r_seq, r_tdc}),
        .full  (w_full),
        .pop   (iReady),
        .dout  (oData),
        .empty (w_empty),
        .level (oLevel)
    );

    assign oEnable   = r_enable;
    assign oBusy     = r_busy;
    assign oValid    = !w_empty;
    assign oOverflow = r_ovf;

endmodule

// File: tb/tb_tdc_readout.sv
// Directed self-checking bench for tdc_readout with a hand-driven TDC model.
module tb_tdc_readout;

    logic        clk;
    logic        rst_n;
    logic        run;
    logic        enable;
    logic        done;
    logic [23:0] tdc;
    logic [31:0] data;
    logic        valid;
    logic        ready;
    logic [4:0]  level;
    logic [15:0] ovf;
    logic        busy;

    int n_checks;
    int n_pass;

    tdc_readout #(
        .DATA_W  (24),
        .SEQ_W   (8),
        .DEPTH   (16),
        .HOLDOFF (4),
        .OVF_W   (16)
    ) dut (
        .iClk      (clk),
        .iRst_n    (rst_n),
        .iRun      (run),
        .oEnable   (enable),
        .iDone     (done),
        .iTDC      (tdc),
        .oData     (data),
        .oValid    (valid),
        .iReady    (ready),
        .oLevel    (level),
        .oOverflow (ovf),
        .oBusy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        ticks(2);
        rst_n = 1'b1;
    endtask

    task automatic wait_enable(input string tag);
        for (int i = 0; i < 40; i++) begin
            if (enable) return;
            tick();
        end
        check(tag, 64'd0, 64'd1);
    endtask

    // Pulses done for one cycle; returns in the capture cycle (done + 1).
    task automatic pulse_done(input logic [23:0] val);
        done = 1'b1;
        tdc  = val;
        tick();
        done = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int max_lvl, got, issued, pend, en_cnt, cyc, seq_err;
        logic [7:0] last_seq;
        n_checks = 0;
        n_pass   = 0;
        run = 1'b1; ready = 1'b0; done = 1'b0; tdc = '0; rst_n = 1'b0;

        // Test 1: reset state, single measurement latency and re-arm spacing
        ticks(3);
        check("rst_enable", {63'd0, enable}, 64'd0);
        check("rst_valid",  {63'd0, valid},  64'd0);
        check("rst_level",  {59'd0, level},  64'd0);
        check("rst_ovf",    {48'd0, ovf},    64'd0);
        check("rst_busy",   {63'd0, busy},   64'd0);
        rst_n = 1'b1;
        wait_enable("t1_arm_timeout");
        tick();
        check("t1_enable_one_pulse", {63'd0, enable}, 64'd0);
        ticks(9);
        pulse_done(24'h00ABCD);
        check("t1_valid_n1", {63'd0, valid}, 64'd0);
        tick();
        check("t1_valid_n2", {63'd0, valid}, 64'd1);
        check("t1_data", {32'd0, data}, 64'h0000_ABCD);
        ticks(3);
        check("t1_no_enable_n5", {63'd0, enable}, 64'd0);
        tick();
        check("t1_enable_n6", {63'd0, enable}, 64'd1);

        // Test 2: fill with no consumer, overflow and sequence gap
        do_reset();
        ready = 1'b0;
        for (int i = 0; i < 20; i++) begin
            wait_enable("t2_arm_timeout");
            ticks(3);
            if (i == 19) run = 1'b0;
            pulse_done(24'h100000 + 24'(i));
        end
        ticks(8);
        check("t2_level", {59'd0, level}, 64'd16);
        check("t2_ovf",   {48'd0, ovf},   64'd4);
        check("t2_busy",  {63'd0, busy},  64'd0);
        ready = 1'b1;
        seq_err = 0;
        for (int i = 0; i < 16; i++) begin
            if (!valid || data !== {8'(i), 24'h100000 + 24'(i)}) seq_err++;
            tick();
        end
        ready = 1'b0;
        check("t2_drain_errors", 64'(seq_err), 64'd0);
        check("t2_empty_after_drain", {63'd0, valid}, 64'd0);
        run = 1'b1;
        wait_enable("t2_rearm_timeout");
        ticks(2);
        run = 1'b0;
        pulse_done(24'h0ABCDE);
        tick();
        check("t2_next_word", {32'd0, data}, {32'd0, 8'd20, 24'h0ABCDE});
        ticks(8);

        // Test 3: continuous consumer, 300 measurements, sequence wrap
        do_reset();
        ready = 1'b1; run = 1'b1;
        max_lvl = 0; got = 0; issued = 0; pend = 0; cyc = 0; seq_err = 0; last_seq = '0;
        while (got < 300 && cyc < 20000) begin
            done = 1'b0;
            if (valid) begin
                if (data !== {8'(got), 24'(got * 7)}) seq_err++;
                last_seq = data[31:24];
                got++;
            end
            if (int'(level) > max_lvl) max_lvl = int'(level);
            if (pend > 0) begin
                pend--;
                if (pend == 0) begin
                    done = 1'b1;
                    tdc  = 24'(issued * 7);
                    issued++;
                    if (issued == 300) run = 1'b0;
                end
            end
            if (enable) pend = 2;
            tick();
            cyc++;
        end
        done = 1'b0;
        check("t3_words",      64'(got), 64'd300);
        check("t3_word_errs",  64'(seq_err), 64'd0);
        check("t3_last_seq",   {56'd0, last_seq}, 64'd43);
        check("t3_ovf",        {48'd0, ovf}, 64'd0);
        check("t3_max_level",  64'(max_lvl), 64'd1);
        ticks(8);

        // Test 4: run dropped during WAIT, measurement still completes
        do_reset();
        ready = 1'b0; run = 1'b1;
        wait_enable("t4_arm_timeout");
        tick();
        run = 1'b0;
        ticks(5);
        pulse_done(24'h004444);
        check("t4_busy_capt", {63'd0, busy}, 64'd1);
        tick();
        check("t4_valid", {63'd0, valid}, 64'd1);
        check("t4_data", {32'd0, data}, {32'd0, 8'd0, 24'h004444});
        en_cnt = 0;
        for (int i = 0; i < 20; i++) begin
            if (enable) en_cnt++;
            tick();
        end
        check("t4_no_rearm", 64'(en_cnt), 64'd0);
        check("t4_busy_idle", {63'd0, busy}, 64'd0);

        // Test 5: stray done pulses in IDLE and HOLD are ignored
        pulse_done(24'hDEAD00);
        ticks(3);
        check("t5_idle_done_level", {59'd0, level}, 64'd1);
        run = 1'b1;
        wait_enable("t5_arm1_timeout");
        ticks(2);
        pulse_done(24'h000222);
        run = 1'b0;
        tick();
        pulse_done(24'hDEAD01);
        ticks(6);
        check("t5_hold_done_level", {59'd0, level}, 64'd2);
        run = 1'b1;
        wait_enable("t5_arm2_timeout");
        run = 1'b0;
        ticks(2);
        pulse_done(24'h000333);
        ticks(7);
        check("t5_level3", {59'd0, level}, 64'd3);
        ready = 1'b1;
        check("t5_word0", {32'd0, data}, {32'd0, 8'd0, 24'h004444});
        tick();
        check("t5_word1", {32'd0, data}, {32'd0, 8'd1, 24'h000222});
        tick();
        check("t5_word2", {32'd0, data}, {32'd0, 8'd2, 24'h000333});
        tick();
        ready = 1'b0;

        // Test 6: push and pop while full, then reset in the middle of WAIT
        do_reset();
        ready = 1'b0; run = 1'b1;
        for (int i = 0; i < 16; i++) begin
            wait_enable("t6_fill_timeout");
            ticks(2);
            pulse_done(24'h600000 + 24'(i));
        end
        wait_enable("t6_arm17_timeout");
        ticks(2);
        pulse_done(24'h6000AA);
        ready = 1'b1;
        tick();
        ready = 1'b0;
        check("t6_level_full", {59'd0, level}, 64'd16);
        check("t6_ovf", {48'd0, ovf}, 64'd0);
        check("t6_head", {32'd0, data}, {32'd0, 8'd1, 24'h600001});
        wait_enable("t6_arm18_timeout");
        tick();
        ready = 1'b1;
        seq_err = 0;
        for (int i = 1; i < 16; i++) begin
            if (data !== {8'(i), 24'h600000 + 24'(i)}) seq_err++;
            tick();
        end
        ready = 1'b0;
        check("t6_drain_errors", 64'(seq_err), 64'd0);
        check("t6_tail", {32'd0, data}, {32'd0, 8'd16, 24'h6000AA});
        check("t6_busy_wait", {63'd0, busy}, 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_rst_enable", {63'd0, enable}, 64'd0);
        check("t6_rst_valid",  {63'd0, valid},  64'd0);
        check("t6_rst_level",  {59'd0, level},  64'd0);
        check("t6_rst_busy",   {63'd0, busy},   64'd0);
        run = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        pulse_done(24'hBAD000);
        ticks(3);
        check("t6_post_rst_done_level", {59'd0, level}, 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
